// File: rtl/div_pkg.sv
// Shared FSM encodings for the divider and the matching multiplier wrapper.
package div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring iteration: shift in a dividend bit, trial-subtract, keep or restore.
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH:0]   i_dsr,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_diff;

    // The partial remainder stays below |Y| <= 2^(WIDTH-1), so the shifted value fits WIDTH+1 bits.
    assign w_shift = {i_rem, i_bit};
    assign w_diff  = {1'b0, w_shift} - {1'b0, i_dsr};
    assign o_qbit  = ~w_diff[WIDTH+1];
    assign o_rem   = WIDTH'(o_qbit ? w_diff : {1'b0, w_shift});

endmodule

// File: rtl/signed_restoring_divider.sv
// Multi-cycle signed divider: magnitudes divided by restoring steps, signs applied in FIX.
module signed_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             valid,
    output logic             dz,
    output logic             ovf,
    output div_state_e       dbg_state
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH:0]   r_dsr;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_dz_pend;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_valid;
    logic             r_dz;
    logic             r_ovf;

    logic [WIDTH:0]   w_x_ext;
    logic [WIDTH:0]   w_y_ext;
    logic [WIDTH:0]   w_x_abs;
    logic [WIDTH:0]   w_y_abs;
    logic [WIDTH-1:0] w_step_rem;
    logic             w_step_qbit;

    // WIDTH+1 bits so that |-2^(WIDTH-1)| is representable.
    assign w_x_ext = {X[WIDTH-1], X};
    assign w_y_ext = {Y[WIDTH-1], Y};
    assign w_x_abs = X[WIDTH-1] ? -w_x_ext : w_x_ext;
    assign w_y_abs = Y[WIDTH-1] ? -w_y_ext : w_y_ext;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem  (r_rem),
        .i_bit  (r_dvd[WIDTH-1]),
        .i_dsr  (r_dsr),
        .o_rem  (w_step_rem),
        .o_qbit (w_step_qbit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_dvd     <= '0;
            r_dsr     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
            r_dz_pend <= 1'b0;
            r_q       <= '0;
            r_r       <= '0;
            r_valid   <= 1'b0;
            r_dz      <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_valid <= 1'b0;
                    if (start) begin
                        r_x       <= X;
                        r_y       <= Y;
                        r_dvd     <= WIDTH'(w_x_abs);
                        r_dsr     <= w_y_abs;
                        r_rem     <= '0;
                        r_quo     <= '0;
                        r_cnt     <= '0;
                        r_q_neg   <= X[WIDTH-1] ^ Y[WIDTH-1];
                        r_r_neg   <= X[WIDTH-1];
                        r_dz_pend <= (Y == '0);
                        r_state   <= (Y == '0) ? S_FIX : S_CALC;
                    end
                end
                S_CALC: begin
                    r_rem <= w_step_rem;
                    r_quo <= {r_quo[WIDTH-2:0], w_step_qbit};
                    r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FIX: begin
                    if (r_dz_pend) begin
                        r_q   <= '1;
                        r_r   <= r_x;
                        r_dz  <= 1'b1;
                        r_ovf <= 1'b0;
                    end else begin
                        // MIN / -1 wraps the magnitude 2^(WIDTH-1) back to MIN naturally.
                        r_q   <= r_q_neg ? -r_quo : r_quo;
                        r_r   <= r_r_neg ? -r_rem : r_rem;
                        r_dz  <= 1'b0;
                        r_ovf <= (r_x == MIN_VAL) && (r_y == '1);
                    end
                    r_valid <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Q         = r_q;
    assign R         = r_r;
    assign valid     = r_valid;
    assign dz        = r_dz;
    assign ovf       = r_ovf;
    assign busy      = (r_state != S_IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_signed_restoring_divider.sv
// Directed bench for the 8-bit signed restoring divider with hand-computed results.
module tb_signed_restoring_divider;
    import div_pkg::*;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic [W-1:0] Q;
    logic [W-1:0] R;
    logic         busy;
    logic         valid;
    logic         dz;
    logic         ovf;
    div_state_e   dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    signed_restoring_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .X         (X),
        .Y         (Y),
        .Q         (Q),
        .R         (R),
        .busy      (busy),
        .valid     (valid),
        .dz        (dz),
        .ovf       (ovf),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives a request that is sampled at the next rising edge (edge 0).
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
        X     = x;
        Y     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int elat, input logic [W-1:0] eq,
                               input logic [W-1:0] er, input logic edz, input logic eovf);
        int lat;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                lat = i;
                break;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(elat));
        check({tag, " q"}, 32'(Q), 32'(eq));
        check({tag, " r"}, 32'(R), 32'(er));
        check({tag, " dz"}, 32'(dz), 32'(edz));
        check({tag, " ovf"}, 32'(ovf), 32'(eovf));
    endtask

    task automatic expect_drop(input string tag);
        @(posedge clk);
        #1;
        check({tag, " valid drop"}, 32'(valid), 32'd0);
        check({tag, " idle busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int extra;
        rst   = 1'b1;
        start = 1'b0;
        X     = '0;
        Y     = '0;
        #2 rst = 1'b0;
        #10;
        check("reset q", 32'(Q), 32'd0);
        check("reset r", 32'(R), 32'd0);
        check("reset valid", 32'(valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset dz", 32'(dz), 32'd0);
        check("reset ovf", 32'(ovf), 32'd0);
        check("reset state", 32'(dbg_state), 32'(S_IDLE));

        // First edge after release must accept the request.
        @(negedge clk);
        rst = 1'b1;
        issue(8'd100, 8'd7);
        check("100/7 busy", 32'(busy), 32'd1);
        check("100/7 state", 32'(dbg_state), 32'(S_CALC));
        wait_result("100/7", 9, 8'd14, 8'd2, 1'b0, 1'b0);
        expect_drop("100/7");

        issue(8'(-100), 8'd7);
        wait_result("-100/7", 9, 8'(-14), 8'(-2), 1'b0, 1'b0);
        issue(8'd100, 8'(-7));
        wait_result("100/-7", 9, 8'(-14), 8'd2, 1'b0, 1'b0);
        issue(8'(-7), 8'(-2));
        wait_result("-7/-2", 9, 8'd3, 8'(-1), 1'b0, 1'b0);
        issue(8'd127, 8'(-128));
        wait_result("127/-128", 9, 8'd0, 8'd127, 1'b0, 1'b0);
        issue(8'(-128), 8'(-128));
        wait_result("-128/-128", 9, 8'd1, 8'd0, 1'b0, 1'b0);
        issue(8'(-128), 8'(-1));
        wait_result("-128/-1", 9, 8'h80, 8'd0, 1'b0, 1'b1);
        issue(8'(-128), 8'd1);
        wait_result("-128/1", 9, 8'h80, 8'd0, 1'b0, 1'b0);

        issue(8'd5, 8'd0);
        check("5/0 state", 32'(dbg_state), 32'(S_FIX));
        wait_result("5/0", 1, 8'hFF, 8'd5, 1'b1, 1'b0);
        expect_drop("5/0");

        // New request issued in the very cycle valid is high.
        issue(8'd100, 8'd7);
        wait_result("b2b first", 9, 8'd14, 8'd2, 1'b0, 1'b0);
        issue(8'd9, 8'd2);
        check("b2b accept busy", 32'(busy), 32'd1);
        wait_result("b2b second", 9, 8'd4, 8'd1, 1'b0, 1'b0);

        // Operand change and extra start while busy must be ignored.
        issue(8'd50, 8'd3);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        X     = 8'd20;
        Y     = 8'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_result("busy ignore", 5, 8'd16, 8'd2, 1'b0, 1'b0);
        extra = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (valid) extra++;
        end
        check("busy ignore extra valid", 32'(extra), 32'd0);
        check("busy ignore idle", 32'(busy), 32'd0);

        // Reset asserted just before edge 5 of an operation.
        issue(8'd100, 8'd7);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        #6;
        rst = 1'b0;
        #1;
        check("midrst q", 32'(Q), 32'd0);
        check("midrst r", 32'(R), 32'd0);
        check("midrst valid", 32'(valid), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst dz", 32'(dz), 32'd0);
        check("midrst ovf", 32'(ovf), 32'd0);
        check("midrst state", 32'(dbg_state), 32'(S_IDLE));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        extra = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (valid) extra++;
        end
        check("midrst no valid", 32'(extra), 32'd0);
        issue(8'd9, 8'd3);
        wait_result("9/3", 9, 8'd3, 8'd0, 1'b0, 1'b0);
        expect_drop("9/3");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
